// File: rtl/mac_rx_arb.sv
// rtl/mac_rx_arb.sv - frame-granular two-port receive arbiter with drop counting
//
// Shares one IP-layer receive path between two mac_rx ports. A port is granted
// for a whole frame; its beats are forwarded through one register stage. Frames
// that start while the path is owned, or that lose an IDLE tie, are discarded
// and counted per port.
//
// Ports:
//   clk, reset               clock; synchronous active-high reset
//   valid_i/start_i/last_i   per-port beat valid and frame markers (2 bits)
//   data_i, keep_i           per-port beat payload, port p at [p*W +: W]
//   cancel_i, crc_err_i      per-port MAC abort / CRC error (last beat only)
//   valid_o/start_o/last_o   forwarded beat and frame markers
//   data_o, keep_o           forwarded payload, held while valid_o = 0
//   cancel_o, crc_err_o      abort pulse / CRC error of the forwarded frame
//   grant_o                  one-hot owner of the forwarded beat, 0 when idle
//   drop_cnt0_o/drop_cnt1_o  saturating dropped-frame counters
module mac_rx_arb #(
  parameter int DATA_W = 16,
  parameter int KEEP_W = DATA_W / 8,
  parameter int CNT_W  = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [1:0]          valid_i,
  input  logic [1:0]          start_i,
  input  logic [1:0]          last_i,
  input  logic [2*DATA_W-1:0] data_i,
  input  logic [2*KEEP_W-1:0] keep_i,
  input  logic [1:0]          cancel_i,
  input  logic [1:0]          crc_err_i,
  output logic                valid_o,
  output logic                start_o,
  output logic                last_o,
  output logic [DATA_W-1:0]   data_o,
  output logic [KEEP_W-1:0]   keep_o,
  output logic                cancel_o,
  output logic                crc_err_o,
  output logic [1:0]          grant_o,
  output logic [CNT_W-1:0]    drop_cnt0_o,
  output logic [CNT_W-1:0]    drop_cnt1_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } state_t;

  state_t     state;
  state_t     state_nxt;
  logic       prio;
  logic       prio_nxt;
  logic [1:0] drop;
  logic [1:0] drop_nxt;

  // A start that arrives together with a MAC cancel never opens a frame.
  logic [1:0] port_start;
  logic [1:0] port_end;
  assign port_start = valid_i & start_i & ~cancel_i;
  assign port_end   = (valid_i & last_i) | cancel_i;

  // Winner of an IDLE arbitration, one-hot; zero outside IDLE.
  logic [1:0] win;
  always_comb begin
    win = 2'b00;
    if (state == IDLE) begin
      if (port_start[0] && (!port_start[1] || !prio)) begin
        win = 2'b01;
      end else if (port_start[1]) begin
        win = 2'b10;
      end
    end
  end

  // Every start that does not win an IDLE arbitration is a dropped frame,
  // including a restart on the granted port itself.
  logic [1:0] drop_ev;
  assign drop_ev = port_start & ~win;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      prio  <= 1'b0;
      drop  <= 2'b00;
    end else begin
      state <= state_nxt;
      prio  <= prio_nxt;
      drop  <= drop_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    prio_nxt  = prio;
    // A drop set by a single-beat frame clears in the same cycle.
    drop_nxt  = (drop | drop_ev) & ~port_end;
    case (state)
      IDLE: begin
        if (win[0]) begin
          state_nxt = last_i[0] ? IDLE : GNT0;
          prio_nxt  = 1'b1;
        end else if (win[1]) begin
          state_nxt = last_i[1] ? IDLE : GNT1;
          prio_nxt  = 1'b0;
        end
      end
      GNT0: begin
        if (cancel_i[0] || (valid_i[0] && (start_i[0] || last_i[0]))) begin
          state_nxt = IDLE;
        end
      end
      GNT1: begin
        if (cancel_i[1] || (valid_i[1] && (start_i[1] || last_i[1]))) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output decode: which port's beat is forwarded this cycle, and aborts
  // ---------------------------------------------------------------------------
  logic       sel;
  logic       fwd;
  logic       abort;
  logic [1:0] owner;

  always_comb begin
    sel   = 1'b0;
    fwd   = 1'b0;
    abort = 1'b0;
    owner = 2'b00;
    case (state)
      IDLE: begin
        owner = win;
        sel   = win[1];
        fwd   = |win;
      end
      GNT0: begin
        owner = 2'b01;
        sel   = 1'b0;
        // A restart without a preceding last is treated like a MAC cancel.
        abort = cancel_i[0] | (valid_i[0] & start_i[0]);
        fwd   = valid_i[0] & ~abort;
      end
      GNT1: begin
        owner = 2'b10;
        sel   = 1'b1;
        abort = cancel_i[1] | (valid_i[1] & start_i[1]);
        fwd   = valid_i[1] & ~abort;
      end
      default: begin
        owner = 2'b00;
      end
    endcase
  end

  logic [DATA_W-1:0] beat_data;
  logic [KEEP_W-1:0] beat_keep;
  logic              beat_start;
  logic              beat_last;
  logic              beat_crc;

  assign beat_data  = sel ? data_i[DATA_W +: DATA_W] : data_i[0 +: DATA_W];
  assign beat_keep  = sel ? keep_i[KEEP_W +: KEEP_W] : keep_i[0 +: KEEP_W];
  assign beat_start = sel ? start_i[1]   : start_i[0];
  assign beat_last  = sel ? last_i[1]    : last_i[0];
  assign beat_crc   = sel ? crc_err_i[1] : crc_err_i[0];

  // ---------------------------------------------------------------------------
  // Output register stage and drop counters
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_o     <= 1'b0;
      start_o     <= 1'b0;
      last_o      <= 1'b0;
      data_o      <= '0;
      keep_o      <= '0;
      cancel_o    <= 1'b0;
      crc_err_o   <= 1'b0;
      grant_o     <= 2'b00;
      drop_cnt0_o <= '0;
      drop_cnt1_o <= '0;
    end else begin
      valid_o   <= fwd;
      start_o   <= fwd & beat_start;
      last_o    <= fwd & beat_last;
      crc_err_o <= fwd & beat_last & beat_crc;
      cancel_o  <= abort;
      grant_o   <= owner;
      if (fwd) begin
        data_o <= beat_data;
        keep_o <= beat_keep;
      end
      if (drop_ev[0] && (drop_cnt0_o != {CNT_W{1'b1}})) begin
        drop_cnt0_o <= drop_cnt0_o + CNT_W'(1);
      end
      if (drop_ev[1] && (drop_cnt1_o != {CNT_W{1'b1}})) begin
        drop_cnt1_o <= drop_cnt1_o + CNT_W'(1);
      end
    end
  end

endmodule

// File: doc/mac_rx_arb.md
# mac_rx_arb

Frame-granular two-port receive arbiter that shares one IP-layer receive path between two `mac_rx` instances (two physical ports). Whole frames are granted with round-robin fairness, beats of the granted frame are forwarded through a single register stage, and frames that start while the path is busy are dropped and counted. There is no buffering, which keeps latency fixed at one cycle. The block sits between the MAC receive layer and the IP layer.

## Interface
- `DATA_W`, 16: data bus width in bits; 16, 32 or 64.
- `KEEP_W`, `DATA_W/8`: byte-enable width.
- `CNT_W`, 16: width of each drop counter.

- `clk`  in  1  clock; one clock domain.
- `reset`  in  1  reset, synchronous, active-high.
- `valid_i`  in  2  beat valid, one bit per port.
- `start_i`  in  2  first beat of a frame; qualified by `valid_i`.
- `last_i`  in  2  final beat of a frame; qualified by `valid_i`.
- `data_i`  in  2*DATA_W  port p occupies bits [p*DATA_W +: DATA_W].
- `keep_i`  in  2*KEEP_W  port p occupies bits [p*KEEP_W +: KEEP_W].
- `cancel_i`  in  2  MAC cancel, one bit per port; not qualified by `valid_i`.
- `crc_err_i`  in  2  CRC error; sampled only on a valid last beat.
- `valid_o`  out  1  forwarded beat valid.
- `start_o`, `last_o`  out  1 each  frame markers of the forwarded beat.
- `data_o`  out  DATA_W  forwarded data.
- `keep_o`  out  KEEP_W  forwarded byte enables.
- `cancel_o`  out  1  abort of the current forwarded frame; single-cycle pulse.
- `crc_err_o`  out  1  CRC error of the forwarded frame; asserted only together with `last_o`.
- `grant_o`  out  2  one-hot current owner; 0 when idle.
- `drop_cnt0_o`, `drop_cnt1_o`  out  CNT_W each  count of dropped frames per port; saturate at all-ones.

## Operation
- FSM states: IDLE, GNT0, GNT1. A round-robin pointer `prio` (1 bit) names the preferred port.
- A port start is `valid_i[p] & start_i[p]`. A port end is `valid_i[p] & last_i[p]`, or `cancel_i[p]`.
- **IDLE**
  - Start on exactly one port p: go to GNTp.
  - Starts on both ports: grant port `prio` and drop the other.
  - On every grant of port p, set `prio` to the other port.
  - Beats without a start are ignored; this covers frames already in progress at reset release.
- **GNTp**
  - Every valid beat of port p is forwarded.
  - Gaps in `valid_i[p]` hold the grant.
  - A valid last beat on p: forward it, with `crc_err_o` = `crc_err_i[p]`, then go to IDLE.
  - `cancel_i[p]`: pulse `cancel_o`, send no beat that cycle, go to IDLE.
  - `start_i[p]` while a frame is in progress (missing last): treat as cancel. Pulse `cancel_o`, go to IDLE, and drop the new frame as below.
- **Drop**
  - A start on a non-granted port, in any state other than winning in IDLE, sets `drop[q]`.
  - The drop counter for that port increments once, saturating.
  - All beats of port q are discarded until port q ends its frame; then `drop[q]` clears.
  - A frame starting on the other port in the same cycle as the granted port's last beat is dropped. The grant frees only in the next cycle.
- **Reset**
  - Applies in any state, including mid-frame: IDLE, `prio` = 0, `drop` = 0, counters = 0.
  - All outputs go to 0.

## Timing
- All outputs are registered. A beat accepted at cycle t appears on the outputs at t+1.
- Latency is fixed at 1 cycle; there is no backpressure.
- `cancel_o` follows the causing `cancel_i` or protocol violation by 1 cycle and lasts 1 cycle.
- `grant_o` reflects the state register. It becomes one-hot in the cycle the first beat appears on `valid_o` and returns to 0 the cycle after `last_o` or `cancel_o`.
- Back-to-back: last on p at t and start on either port at t+1 is granted at t+1. No idle bubble is required.
- `data_o`, `keep_o`: hold their last value when `valid_o` = 0. `start_o`, `last_o`, `crc_err_o`: 0 when `valid_o` = 0.

## Test plan
- **Single frame:** port 0 sends a 4-beat frame with data 0x0001..0x0004 and `crc_err_i` = 0.
  - Outputs show identical beats 1 cycle later, `start_o` on the first, `last_o` on the fourth, and `grant_o` = 01 for 4 cycles.
- **Simultaneous starts after reset** (`prio` = 0):
  - Port 0 is forwarded and port 1 is dropped; `drop_cnt1_o` = 1.
  - Repeat the simultaneous starts: port 1 is forwarded and `drop_cnt0_o` = 1.
- **Busy drop:** port 1 starts a 3-beat frame on the second beat of a 5-beat port-0 frame.
  - Port 0 passes intact, `drop_cnt1_o` = 1, and no port-1 beat appears.
- **Cancel mid-frame:** `cancel_i[0]` on beat 3 of a port-0 frame.
  - `cancel_o` pulses one cycle later, no further beats appear, and a port-1 start in the next cycle is granted.
- **CRC error and handoff:** port 0 sends its last beat with `crc_err_i[0]` = 1 at t, and port 1 starts at t+1.
  - `crc_err_o` = 1 with `last_o` at t+1, and the port-1 frame appears from t+2.
- **Reset and saturation:**
  - Assert `reset` mid-frame: all outputs are 0 the next cycle, and trailing beats of that frame are ignored.
  - With `CNT_W` = 2, drop 5 frames on port 1: `drop_cnt1_o` stays at 3.
